// File: rtl/operand_forward_ctrl.sv
// operand_forward_ctrl: registered EX operand-forwarding selects, load-use stall,
// taken-branch bubble insertion and saturating stall/flush event counters.
module operand_forward_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_hold,
   input  logic             i_id_valid,
   input  logic [4:0]       i_id_rs1,
   input  logic [4:0]       i_id_rs2,
   input  logic             i_id_rs1_used,
   input  logic             i_id_rs2_used,
   input  logic [4:0]       i_id_rd,
   input  logic             i_id_regwrite,
   input  logic             i_id_memread,
   input  logic             i_ex_flush,
   output logic [1:0]       o_fwd_a_sel,
   output logic [1:0]       o_fwd_b_sel,
   output logic             o_stall,
   output logic [CNT_W-1:0] o_stall_count,
   output logic [CNT_W-1:0] o_flush_count
);
   // stage records, index 0 = EX, 1 = MEM, 2 = WB
   logic [2:0]      r_v;
   logic [2:0]      r_rw;
   logic [2:0][4:0] r_rd;
   logic            r_ex_mr;
   logic [1:0]      r_a_sel;
   logic [1:0]      r_b_sel;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [2:0]      w_hit_a;
   logic [2:0]      w_hit_b;
   logic [1:0]      w_sel_a;
   logic [1:0]      w_sel_b;
   logic            w_lu;
   logic            w_bubble;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         w_hit_a[k] = r_v[k] & r_rw[k] & (r_rd[k] == i_id_rs1) & (|i_id_rs1);
         w_hit_b[k] = r_v[k] & r_rw[k] & (r_rd[k] == i_id_rs2) & (|i_id_rs2);
      end
   end

   assign w_sel_a = w_hit_a[0] ? 2'd1 : w_hit_a[1] ? 2'd2 : w_hit_a[2] ? 2'd3 : 2'd0;
   assign w_sel_b = w_hit_b[0] ? 2'd1 : w_hit_b[1] ? 2'd2 : w_hit_b[2] ? 2'd3 : 2'd0;

   assign w_lu = (i_id_rs1_used & (i_id_rs1 == r_rd[0])) |
                 (i_id_rs2_used & (i_id_rs2 == r_rd[0]));
   assign o_stall = i_id_valid & r_v[0] & r_ex_mr & (|r_rd[0]) & w_lu &
                    ~i_ex_flush & ~i_hold;
   assign w_bubble = ~i_id_valid | o_stall | i_ex_flush;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v         <= '0;
         r_rw        <= '0;
         r_rd        <= '0;
         r_ex_mr     <= 1'b0;
         r_a_sel     <= 2'd0;
         r_b_sel     <= 2'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (!i_hold) begin
         r_v     <= {r_v[1:0], ~w_bubble};
         r_rw    <= {r_rw[1:0], i_id_regwrite};
         r_rd    <= {r_rd[1:0], i_id_rd};
         r_ex_mr <= i_id_memread;
         r_a_sel <= w_bubble ? 2'd0 : w_sel_a;
         r_b_sel <= w_bubble ? 2'd0 : w_sel_b;
         if (o_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (i_ex_flush && i_id_valid && !(&r_flush_cnt))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign o_fwd_a_sel   = r_a_sel;
   assign o_fwd_b_sel   = r_b_sel;
   assign o_stall_count = r_stall_cnt;
   assign o_flush_count = r_flush_cnt;
endmodule

// File: tb/tb_operand_forward_ctrl.sv
// tb_operand_forward_ctrl: directed and random stimulus against a history-queue
// model of the forwarding controller; a 2-bit-counter instance checks saturation.
module tb_operand_forward_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, hold, id_valid, u1, u2, rw, mr, flush;
   logic [4:0] rs1, rs2, rd;
   logic [1:0] a_sel, b_sel, a2, b2, sc2, fc2;
   logic       stall, stall2, last_stall;
   logic [15:0] sc, fc;
   int passed = 0, total = 0;

   operand_forward_ctrl #(.CNT_W(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(u1), .i_id_rs2_used(u2),
      .i_id_rd(rd), .i_id_regwrite(rw), .i_id_memread(mr), .i_ex_flush(flush),
      .o_fwd_a_sel(a_sel), .o_fwd_b_sel(b_sel), .o_stall(stall),
      .o_stall_count(sc), .o_flush_count(fc));

   operand_forward_ctrl #(.CNT_W(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(u1), .i_id_rs2_used(u2),
      .i_id_rd(rd), .i_id_regwrite(rw), .i_id_memread(mr), .i_ex_flush(flush),
      .o_fwd_a_sel(a2), .o_fwd_b_sel(b2), .o_stall(stall2),
      .o_stall_count(sc2), .o_flush_count(fc2));

   // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB
   typedef struct { bit v; bit rw; bit mr; logic [4:0] rd; } rec_t;
   rec_t hist [3];
   int m_a, m_b, m_sc, m_fc;

   function automatic int src_sel(logic [4:0] s);
      if (s == 0) return 0;
      for (int i = 0; i < 3; i++)
         if (hist[i].v && hist[i].rw && hist[i].rd == s) return i + 1;
      return 0;
   endfunction

   function automatic bit m_stall();
      return id_valid && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
             ((u1 && rs1 == hist[0].rd) || (u2 && rs2 == hist[0].rd)) && !flush && !hold;
   endfunction

   function automatic int sat3(int x);
      return x > 3 ? 3 : x;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) hist[i] = '{v: 0, rw: 0, mr: 0, rd: 5'd0};
      m_a = 0; m_b = 0; m_sc = 0; m_fc = 0;
   endtask

   task automatic model_adv();
      bit st, bub;
      if (hold) return;
      st  = m_stall();
      bub = !id_valid || st || flush;
      if (st) m_sc++;
      if (flush && id_valid) m_fc++;
      m_a = bub ? 0 : src_sel(rs1);
      m_b = bub ? 0 : src_sel(rs2);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{v: !bub, rw: rw, mr: mr, rd: rd};
   endtask

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%0d required=%0d", n, act, exp);
      else passed++;
   endtask

   task automatic compare();
      chk("a_sel", 32'(a_sel), 32'(m_a));
      chk("b_sel", 32'(b_sel), 32'(m_b));
      chk("stall", 32'(stall), 32'(m_stall()));
      chk("stall_count", 32'(sc), 32'(m_sc));
      chk("flush_count", 32'(fc), 32'(m_fc));
      chk("stall_w2", 32'(stall2), 32'(m_stall()));
      chk("sat_stall_count", 32'(sc2), 32'(sat3(m_sc)));
      chk("sat_flush_count", 32'(fc2), 32'(sat3(m_fc)));
   endtask

   task automatic cyc(bit v, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                      bit uu1, bit uu2, bit w, bit m, bit f, bit h);
      id_valid = v; rd = d; rs1 = s1; rs2 = s2; u1 = uu1; u2 = uu2;
      rw = w; mr = m; flush = f; hold = h;
      @(negedge clk);
      compare();
      last_stall = stall;
      @(posedge clk);
      model_adv();
      #1;
   endtask

   task automatic alu(logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
      cyc(1, d, s1, s2, 1, 1, 1, 0, 0, 0);
   endtask

   task automatic ld(logic [4:0] d, logic [4:0] s1);
      cyc(1, d, s1, 5'd0, 1, 0, 1, 1, 0, 0);
   endtask

   initial begin
      rst_n = 1'b1; hold = 0; id_valid = 0; u1 = 0; u2 = 0; rw = 0; mr = 0; flush = 0;
      rs1 = 0; rs2 = 0; rd = 0; last_stall = 0;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_a_sel", 32'(a_sel), 0);
      chk("rst_b_sel", 32'(b_sel), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_counts", 32'(sc) + 32'(fc), 0);
      @(posedge clk); #1; rst_n = 1'b1;

      // back-to-back ALU dependency
      alu(5, 1, 2); alu(6, 5, 5);
      chk("b2b_a", 32'(a_sel), 1); chk("b2b_b", 32'(b_sel), 1);
      // distance 2, 3, 4
      alu(7, 1, 2); alu(10, 1, 2); alu(11, 7, 7);
      chk("dist2_a", 32'(a_sel), 2); chk("dist2_b", 32'(b_sel), 2);
      alu(7, 1, 2); alu(10, 1, 2); alu(12, 1, 2); alu(13, 7, 1);
      chk("dist3_a", 32'(a_sel), 3); chk("dist3_b", 32'(b_sel), 0);
      alu(7, 1, 2); alu(10, 1, 2); alu(12, 1, 2); alu(14, 1, 2); alu(13, 7, 7);
      chk("dist4_a", 32'(a_sel), 0);
      // load-use
      ld(8, 1); alu(9, 8, 1);
      chk("lu_stall", 32'(last_stall), 1);
      chk("lu_bubble_a", 32'(a_sel), 0);
      alu(9, 8, 1);
      chk("lu_after_stall", 32'(last_stall), 0);
      chk("lu_a", 32'(a_sel), 2); chk("lu_b", 32'(b_sel), 0);
      chk("lu_count", 32'(sc), 1);
      // priority and x0
      alu(3, 1, 2); alu(3, 1, 2); alu(4, 3, 3);
      chk("prio_a", 32'(a_sel), 1);
      alu(0, 1, 2); alu(4, 0, 0);
      chk("x0_a", 32'(a_sel), 0); chk("x0_b", 32'(b_sel), 0);
      // flush wins over load-use
      ld(8, 1); cyc(1, 9, 8, 1, 1, 1, 1, 0, 1, 0);
      chk("fl_stall", 32'(last_stall), 0);
      chk("fl_bubble", 32'(a_sel), 0);
      chk("fl_count", 32'(fc), 1); chk("fl_stall_count", 32'(sc), 1);
      // hold mid-dependency
      alu(5, 1, 2); alu(6, 5, 5);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 7, 6, 6, 1, 1, 1, 0, 0, 1);
         chk("hold_a", 32'(a_sel), 1);
      end
      alu(7, 6, 6);
      chk("post_hold_a", 32'(a_sel), 1);
      // saturation: four more load-use stalls, five in total
      for (int i = 0; i < 4; i++) begin
         ld(8, 1); alu(9, 8, 1); alu(9, 8, 1);
      end
      chk("sat16", 32'(sc), 5); chk("sat2", 32'(sc2), 3);
      // asynchronous reset mid-cycle
      @(negedge clk); #1 rst_n = 1'b0;
      #1;
      chk("arst_a", 32'(a_sel), 0); chk("arst_b", 32'(b_sel), 0);
      chk("arst_stall", 32'(stall), 0);
      chk("arst_sc", 32'(sc), 0); chk("arst_fc", 32'(fc), 0); chk("arst_sc2", 32'(sc2), 0);
      model_reset();
      @(posedge clk); #1; rst_n = 1'b1;
      // randomized traffic over a small register set to provoke hazards
      for (int n = 0; n < 3000; n++)
         cyc($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
